// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the sample fetch sequencer
package fetch_pkg;

  localparam int DEF_DATA_W  = 8;
  localparam int DEF_ADDR_W  = 8;
  // x and y of one sample occupy two consecutive memory words
  localparam int ADDR_STRIDE = 2;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_REQ_X  = 3'd1,
    S_REQ_Y  = 3'd2,
    S_LOAD_Y = 3'd3,
    S_OUT    = 3'd4,
    S_DONE   = 3'd5
  } state_e;

endpackage

// File: rtl/sample_fetcher.sv
// rtl/sample_fetcher.sv - reads (x, y) byte pairs from sample memory and streams them downstream
module sample_fetcher
  import fetch_pkg::*;
#(
  parameter int                DATA_W    = DEF_DATA_W,
  parameter int                ADDR_W    = DEF_ADDR_W,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] num_samples,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read_en,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] sample_x,
  output logic [DATA_W-1:0] sample_y,
  output logic              sample_valid,
  input  logic              sample_ready,
  output logic              busy,
  output logic              done
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] count_q, count_d;
  logic [ADDR_W-1:0] idx_q,   idx_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic [DATA_W-1:0] x_q,     x_d;
  logic [DATA_W-1:0] y_q,     y_d;

  // Next-state logic: memory data arrives one cycle after its request, so x is
  // captured in REQ_Y (answering REQ_X) and y in LOAD_Y (answering REQ_Y).
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    x_d     = x_q;
    y_d     = y_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (num_samples != '0) begin
            count_d = num_samples;
            idx_d   = '0;
            addr_d  = BASE_ADDR;
            state_d = S_REQ_X;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_REQ_X: state_d = S_REQ_Y;
      S_REQ_Y: begin
        x_d     = mem_rdata;
        state_d = S_LOAD_Y;
      end
      S_LOAD_Y: begin
        y_d     = mem_rdata;
        state_d = S_OUT;
      end
      S_OUT: begin
        if (sample_ready) begin
          if (idx_q == count_q - ADDR_W'(1)) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + ADDR_W'(1);
            // address arithmetic wraps modulo 2^ADDR_W by design
            addr_d  = addr_q + ADDR_W'(ADDR_STRIDE);
            state_d = S_REQ_X;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any run in progress.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      count_q <= '0;
      idx_q   <= '0;
      addr_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

  // Outputs decoded from state; memory is only touched in the two request states.
  always_comb begin
    mem_read_en  = (state_q == S_REQ_X) || (state_q == S_REQ_Y);
    mem_addr     = (state_q == S_REQ_Y) ? addr_q + ADDR_W'(1) : addr_q;
    sample_valid = (state_q == S_OUT);
    busy         = (state_q != S_IDLE);
    done         = (state_q == S_DONE);
    sample_x     = x_q;
    sample_y     = y_q;
  end

endmodule

// File: doc/sample_fetcher.md
# sample_fetcher

Read sequencer between the regression datapath and the 8-bit sample memory. On `start` it reads `num_samples` (x, y) byte pairs from consecutive memory addresses. It drives the memory's address and read-enable, pairs the returned bytes, and presents each pair downstream on a valid/ready handshake. It pulses `done` after the last pair is accepted.

## Interface
Parameters:
- `DATA_W`, 8, width of a memory word and of each sample component
- `ADDR_W`, 8, memory address width
- `BASE_ADDR`, 0, address of x of sample 0

Ports:
- `clk`  in  1  clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `start`  in  1  begin a fetch run; sampled only in IDLE
- `num_samples`  in  ADDR_W  pair count; latched on accepted `start`
- `mem_addr`  out  ADDR_W  memory address (to memory `addr`)
- `mem_read_en`  out  1  memory read request
- `mem_rdata`  in  DATA_W  memory read data (from memory `out_bus`); valid the cycle after the request
- `sample_x`, `sample_y`  out  DATA_W  current pair, registered
- `sample_valid`  out  1  pair on `sample_x`/`sample_y` is valid
- `sample_ready`  in  1  downstream accepts the pair
- `busy`  out  1  high in any state except IDLE
- `done`  out  1  one-cycle pulse at end of run

## Operation
- Memory layout: sample i has x at `BASE_ADDR+2i` and y at `BASE_ADDR+2i+1`. Addresses are computed mod 2^ADDR_W and wrap silently.
- FSM states: IDLE, REQ_X, REQ_Y, LOAD_Y, OUT, DONE.
- IDLE:
  - `start`=1 and `num_samples`≠0: latch the count, set addr←BASE_ADDR and idx←0, go to REQ_X.
  - `start`=1 and `num_samples`=0: go to DONE; no memory access.
- REQ_X: `mem_read_en`=1, `mem_addr`=addr; go to REQ_Y.
- REQ_Y: `mem_read_en`=1, `mem_addr`=addr+1; register `mem_rdata` into x; go to LOAD_Y.
- LOAD_Y: `mem_read_en`=0; register `mem_rdata` into y; go to OUT.
- OUT: `sample_valid`=1. On `sample_ready`=1:
  - if idx = count−1, go to DONE;
  - otherwise idx←idx+1, addr←addr+2, go to REQ_X.
  - Without `sample_ready`, stay in OUT with `sample_x`/`sample_y` held stable.
- DONE: `done`=1 for exactly one cycle; go to IDLE.
- `start` outside IDLE is ignored. `num_samples` changes after latch have no effect.
- `sample_x`/`sample_y` keep their last values after the run ends; they are undefined-free (0 after reset).
- `mem_read_en` is never high outside REQ_X/REQ_Y. The block never writes memory.

## Timing
- Reset values: `mem_addr`=0, `mem_read_en`=0, `sample_x`=0, `sample_y`=0, `sample_valid`=0, `busy`=0, `done`=0. State is IDLE.
- Asserting `rst` low mid-run aborts the run immediately. No `done` pulse is produced; the next run needs a fresh `start`.
- `start` sampled at edge E: REQ_X occupies E..E+1. `sample_valid` is first high in the cycle after edge E+3, so latency is 4 cycles.
- Throughput with `sample_ready` held high: one pair per 4 cycles.
- The OUT-cycle handshake is followed by REQ_X on the next cycle (no bubble).
- The `done` pulse occupies the cycle after the final handshake. `busy` falls with the return to IDLE, one cycle after `done`.
- Zero-count run: `done` is high one cycle after `start` is sampled.
- Count of 2^ADDR_W−1 pairs makes addresses wrap. Correct pairing is still required.

## Structure
- Shared package `fetch_pkg` holds:
  - the state enum (IDLE..DONE);
  - default `DATA_W`/`ADDR_W` constants;
  - the `ADDR_STRIDE`=2 constant.
- Single flat module. The index/address counter stays inline; it is too small to justify a separate sub-module.
- The memory instance itself lives in the parent, not in this block.

## Test plan
- Memory preloaded M[0..3]={3,7,5,11}, `num_samples`=2, `sample_ready`=1. Expect:
  - pairs (3,7) then (5,11);
  - `mem_addr` sequence 0,1,2,3;
  - `done` one cycle after the second handshake;
  - first `sample_valid` 4 cycles after `start`.
- Same memory, `sample_ready` held low for 5 cycles in the first OUT. Expect (3,7) stable for 6 cycles and no memory reads during the stall, then normal completion.
- `num_samples`=0. Expect `done` on the next cycle, `mem_read_en` never asserted, and `sample_valid` never asserted.
- `BASE_ADDR`=254, M[254]=9, M[255]=1, M[0]=4, M[1]=2, count=2. Expect pairs (9,1), (4,2) across the address wrap.
- `rst` driven low while in REQ_Y of the second sample. Expect:
  - all outputs at reset values immediately;
  - no `done`;
  - a subsequent `start` replays from sample 0.
- `start` re-asserted mid-run with a different `num_samples`. Expect it ignored and the original count completed.
